lcd_scroll_ctrl: RTL and testbench

- Frame-synchronous controller for the checkerboard scroll offsets that feed the LCD pixel colour logic.
- Shares the offset registers between two requesters: an internal auto-scroll stepper gated by the debounced user button, and an external host with a 4-phase req/ack handshake.
- Every offset change lands exactly at a frame boundary (VSYNC falling edge), so a frame never tears.
- Sits between lcd_driver (VSYNC source) and the colour mux (consumer of OFS_X/OFS_Y), in the PIXEL_CLK domain.

---
 rtl/lcd_pkg.sv | 18 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/lcd_scroll_ctrl.sv | 131 +++++++++++++
 tb/tb_lcd_scroll_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared constants for the LCD scroll controller: offset width, default
// auto-scroll steps, default debounce length and the host FSM encoding.
package lcd_pkg;

  localparam int OFS_W               = 8;
  localparam int STEP_X_DEF          = 3;
  localparam int STEP_Y_DEF          = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 90000;

  typedef logic [OFS_W-1:0] ofs_t;

  // Host handshake FSM encoding; 2'd3 is unused and falls back to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronises the raw user button and only lets RUN change after the
// synchronised level has differed from RUN for DEBOUNCE_CYCLES samples in
// a row.
// Ports:
//   PIXEL_CLK  clock
//   RESETn     asynchronous active-low reset
//   BTN_USER   raw asynchronous button (high = run)
//   RUN        debounced button state
module btn_debounce
  import lcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic PIXEL_CLK,
  input  logic RESETn,
  input  logic BTN_USER,
  output logic RUN
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s1;
  logic             btn_s2;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge PIXEL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      stable_cnt <= '0;
      RUN        <= 1'b0;
    end else begin
      btn_s1 <= BTN_USER;
      btn_s2 <= btn_s1;
      // Any sample agreeing with RUN restarts the count, so only an
      // unbroken run of differing samples can flip the output.
      if (btn_s2 == RUN) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        RUN        <= ~RUN;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_scroll_ctrl.sv
// lcd_scroll_ctrl
// Frame-synchronous owner of the checkerboard scroll offsets. Offsets only
// change on the frame boundary (VSYNC falling edge); a pending host value
// takes priority over the auto-scroll step for that frame.
//
// state | meaning
// IDLE  | no host request outstanding, HOST_REQ sampled every cycle
// PEND  | host value held, waiting for the next frame boundary
// ACK   | host value applied, HOST_ACK high until HOST_REQ falls
//
// Ports:
//   PIXEL_CLK         clock
//   RESETn            asynchronous active-low reset
//   VSYNC             active-low frame sync from lcd_driver (asynchronous)
//   BTN_USER          raw run button
//   HOST_REQ/X/Y      host offset update request and value
//   HOST_ACK          host handshake acknowledge
//   OFS_X/OFS_Y       current scroll offsets
//   FRAME_TICK        one-cycle pulse on the cycle offsets may change
//   RUN               debounced button state
module lcd_scroll_ctrl
  import lcd_pkg::*;
#(
  parameter int STEP_X          = STEP_X_DEF,
  parameter int STEP_Y          = STEP_Y_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             PIXEL_CLK,
  input  logic             RESETn,
  input  logic             VSYNC,
  input  logic             BTN_USER,
  input  logic             HOST_REQ,
  input  logic [OFS_W-1:0] HOST_X,
  input  logic [OFS_W-1:0] HOST_Y,
  output logic             HOST_ACK,
  output logic [OFS_W-1:0] OFS_X,
  output logic [OFS_W-1:0] OFS_Y,
  output logic             FRAME_TICK,
  output logic             RUN
);

  localparam ofs_t STEP_X_V = OFS_W'(STEP_X);
  localparam ofs_t STEP_Y_V = OFS_W'(STEP_Y);

  logic       vs_s1;
  logic       vs_s2;
  logic       vs_s3;
  logic       fall;
  logic [1:0] state;
  ofs_t       hold_x;
  ofs_t       hold_y;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .PIXEL_CLK(PIXEL_CLK),
    .RESETn   (RESETn),
    .BTN_USER (BTN_USER),
    .RUN      (RUN)
  );

  // Synchroniser flops reset high so a VSYNC that is already low when reset
  // releases still produces one boundary.
  always_ff @(posedge PIXEL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_s3      <= 1'b1;
      FRAME_TICK <= 1'b0;
    end else begin
      vs_s1      <= VSYNC;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      FRAME_TICK <= fall;
    end
  end

  assign fall = vs_s3 & ~vs_s2;

  // Offsets are qualified by fall rather than FRAME_TICK so they land on
  // the same edge that raises FRAME_TICK.
  always_ff @(posedge PIXEL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= ST_IDLE;
      hold_x   <= '0;
      hold_y   <= '0;
      HOST_ACK <= 1'b0;
      OFS_X    <= '0;
      OFS_Y    <= '0;
    end else begin
      if (fall) begin
        if (state == ST_PEND) begin
          OFS_X <= hold_x;
          OFS_Y <= hold_y;
        end else if (RUN) begin
          OFS_X <= OFS_X + STEP_X_V;
          OFS_Y <= OFS_Y + STEP_Y_V;
        end
      end

      case (state)
        ST_IDLE: begin
          // A request arriving on a boundary is only captured here; it
          // waits for the next boundary to be applied.
          if (HOST_REQ) begin
            hold_x <= HOST_X;
            hold_y <= HOST_Y;
            state  <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (fall) begin
            HOST_ACK <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!HOST_REQ) begin
            HOST_ACK <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          HOST_ACK <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_scroll_ctrl.sv
// tb_lcd_scroll_ctrl
// Directed scenarios followed by randomised traffic; a frame-level model
// predicts every output each cycle, and literal expectations pin the model.
module tb_lcd_scroll_ctrl;

  localparam int DEB = 4;
  localparam int SX  = 3;
  localparam int SY  = 2;

  logic       PIXEL_CLK = 1'b0;
  logic       RESETn    = 1'b0;
  logic       VSYNC     = 1'b1;
  logic       BTN_USER  = 1'b0;
  logic       HOST_REQ  = 1'b0;
  logic [7:0] HOST_X    = 8'h00;
  logic [7:0] HOST_Y    = 8'h00;
  logic       HOST_ACK;
  logic [7:0] OFS_X;
  logic [7:0] OFS_Y;
  logic       FRAME_TICK;
  logic       RUN;

  int n_cmp = 0;
  int n_err = 0;

  lcd_scroll_ctrl #(
    .STEP_X(SX),
    .STEP_Y(SY),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .PIXEL_CLK (PIXEL_CLK),
    .RESETn    (RESETn),
    .VSYNC     (VSYNC),
    .BTN_USER  (BTN_USER),
    .HOST_REQ  (HOST_REQ),
    .HOST_X    (HOST_X),
    .HOST_Y    (HOST_Y),
    .HOST_ACK  (HOST_ACK),
    .OFS_X     (OFS_X),
    .OFS_Y     (OFS_Y),
    .FRAME_TICK(FRAME_TICK),
    .RUN       (RUN)
  );

  always #5 PIXEL_CLK = ~PIXEL_CLK;

  // Model: input histories as seen at each edge, plus frame-level state.
  bit         vh [3];   // VSYNC sampled 1, 2, 3 edges ago
  bit         bh [2];   // BTN_USER sampled 1, 2 edges ago
  int         m_stable;
  bit         m_run, m_tick, m_pend, m_ack;
  logic [7:0] m_x, m_y, m_hx, m_hy;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) vh[i] = 1'b1;
    for (int i = 0; i < 2; i++) bh[i] = 1'b0;
    m_stable = 0;
    m_run = 0; m_tick = 0; m_pend = 0; m_ack = 0;
    m_x = 0; m_y = 0; m_hx = 0; m_hy = 0;
  endtask

  initial model_reset();

  always @(posedge PIXEL_CLK) begin
    bit tick, run_old, p0, a0;
    if (!RESETn) begin
      model_reset();
    end else begin
      // A frame boundary is seen three edges after VSYNC was first sampled low.
      tick    = vh[2] && !vh[1];
      run_old = m_run;
      p0      = m_pend;
      a0      = m_ack;
      if (bh[1] != m_run) begin
        m_stable++;
        if (m_stable == DEB) begin
          m_run    = !m_run;
          m_stable = 0;
        end
      end else begin
        m_stable = 0;
      end
      if (tick) begin
        if (p0) begin
          m_x = m_hx; m_y = m_hy;
          m_ack = 1; m_pend = 0;
        end else if (run_old) begin
          m_x = 8'((int'(m_x) + SX) % 256);
          m_y = 8'((int'(m_y) + SY) % 256);
        end
      end
      if (!p0 && !a0 && HOST_REQ) begin
        m_hx = HOST_X; m_hy = HOST_Y; m_pend = 1;
      end
      if (a0 && !HOST_REQ) m_ack = 0;
      m_tick = tick;
      vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = VSYNC;
      bh[1] = bh[0]; bh[0] = BTN_USER;
    end
  end

  always @(negedge PIXEL_CLK) begin
    logic [18:0] got, exp;
    got = {FRAME_TICK, RUN, HOST_ACK, OFS_X, OFS_Y};
    if (!RESETn) exp = '0;
    else         exp = {m_tick, m_run, m_ack, m_x, m_y};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cycle_model t=%0t: got tick/run/ack/x/y=%b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
               $time, got[18], got[17], got[16], got[15:8], got[7:0],
               exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drv();
    @(negedge PIXEL_CLK);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) drv();
  endtask

  task automatic do_reset();
    RESETn = 1'b0; VSYNC = 1'b1; BTN_USER = 1'b0; HOST_REQ = 1'b0;
    wait_n(2);
    RESETn = 1'b1;
    drv();
  endtask

  task automatic vsync_pulse(input int low_len, output int ticks);
    VSYNC = 1'b0;
    ticks = 0;
    for (int i = 1; i <= low_len + 5; i++) begin
      @(negedge PIXEL_CLK);
      ticks += int'(FRAME_TICK);
      #1;
      if (i == low_len) VSYNC = 1'b1;
    end
  endtask

  initial begin
    int ticks, k;
    int vs_cnt, bt_cnt, rst_hold;

    wait_n(2);
    check("reset_ofs", {16'h0, OFS_X, OFS_Y}, 32'h0);
    check("reset_flags", {29'h0, HOST_ACK, FRAME_TICK, RUN}, 32'h0);
    RESETn = 1'b1;
    drv();

    // Debounce: RUN flips on the edge after the 4th stable synced sample.
    BTN_USER = 1'b1;
    wait_n(5);
    check("run_not_yet", {31'h0, RUN}, 32'h0);
    drv();
    check("run_set", {31'h0, RUN}, 32'h1);
    wait_n(4);

    // First frame with latency measurement.
    VSYNC = 1'b0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge PIXEL_CLK);
      #1;
      if (FRAME_TICK) begin k = i; break; end
    end
    check("tick_latency", k, 32'd3);
    check("ofs_frame1", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'd3, 8'd2});
    drv(); drv(); drv(); drv();
    VSYNC = 1'b1;
    wait_n(4);
    vsync_pulse(8, ticks);
    check("one_tick_long_low", ticks, 32'd1);
    check("ofs_frame2", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'd6, 8'd4});
    vsync_pulse(3, ticks);
    check("ofs_frame3", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'd9, 8'd6});

    // Short glitch does not change RUN; frame leaves offsets alone.
    do_reset();
    BTN_USER = 1'b1;
    wait_n(2);
    BTN_USER = 1'b0;
    wait_n(8);
    vsync_pulse(4, ticks);
    check("glitch_run", {31'h0, RUN}, 32'h0);
    check("glitch_ofs", {16'h0, OFS_X, OFS_Y}, 32'h0);

    // Host preset to 254/255, then wrap on the auto step.
    BTN_USER = 1'b1;
    wait_n(10);
    HOST_REQ = 1'b1; HOST_X = 8'd254; HOST_Y = 8'd255;
    wait_n(2);
    vsync_pulse(4, ticks);
    check("preset_ofs", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'd254, 8'd255});
    check("preset_ack", {31'h0, HOST_ACK}, 32'h1);
    HOST_REQ = 1'b0;
    wait_n(2);
    vsync_pulse(4, ticks);
    check("wrap_ofs", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'd1, 8'd1});

    // Host load pre-empts the step for one frame only.
    HOST_REQ = 1'b1; HOST_X = 8'h40; HOST_Y = 8'h80;
    wait_n(2);
    vsync_pulse(4, ticks);
    check("host_ofs", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'h40, 8'h80});
    wait_n(3);
    check("ack_held", {31'h0, HOST_ACK}, 32'h1);
    HOST_REQ = 1'b0;
    drv();
    check("ack_dropped", {31'h0, HOST_ACK}, 32'h0);
    vsync_pulse(4, ticks);
    check("step_after_host", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'h43, 8'h82});

    // Request arriving on the boundary edge waits for the next frame.
    BTN_USER = 1'b0;
    wait_n(10);
    check("run_cleared", {31'h0, RUN}, 32'h0);
    VSYNC = 1'b0;
    drv(); drv();
    HOST_REQ = 1'b1; HOST_X = 8'h11; HOST_Y = 8'h22;
    wait_n(4);
    VSYNC = 1'b1;
    wait_n(4);
    check("late_req_ofs", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'h43, 8'h82});
    check("late_req_noack", {31'h0, HOST_ACK}, 32'h0);
    vsync_pulse(4, ticks);
    check("late_req_applied", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'h11, 8'h22});
    check("late_req_ack", {31'h0, HOST_ACK}, 32'h1);
    HOST_REQ = 1'b0;
    wait_n(2);

    // Reset while pending discards the held value; request is re-latched.
    HOST_REQ = 1'b1; HOST_X = 8'h55; HOST_Y = 8'h66;
    wait_n(2);
    RESETn = 1'b0;
    drv();
    check("rst_pend_ofs", {16'h0, OFS_X, OFS_Y}, 32'h0);
    check("rst_pend_ack", {31'h0, HOST_ACK}, 32'h0);
    drv();
    RESETn = 1'b1;
    wait_n(2);
    vsync_pulse(4, ticks);
    check("relatch_ofs", {16'h0, OFS_X, OFS_Y}, {16'h0, 8'h55, 8'h66});
    check("relatch_ack", {31'h0, HOST_ACK}, 32'h1);
    HOST_REQ = 1'b0;
    wait_n(2);

    // Randomised traffic, checked cycle by cycle against the model.
    vs_cnt = 5; bt_cnt = 5; rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (vs_cnt == 0) begin
        VSYNC  = ~VSYNC;
        vs_cnt = VSYNC ? int'($urandom_range(3, 15)) : int'($urandom_range(1, 6));
      end else begin
        vs_cnt--;
      end
      if (bt_cnt == 0) begin
        BTN_USER = ~BTN_USER;
        bt_cnt   = int'($urandom_range(1, 12));
      end else begin
        bt_cnt--;
      end
      if (!HOST_REQ && !HOST_ACK && $urandom_range(0, 7) == 0) begin
        HOST_X   = 8'($urandom);
        HOST_Y   = 8'($urandom);
        HOST_REQ = 1'b1;
      end else if (HOST_REQ && HOST_ACK && $urandom_range(0, 3) == 0) begin
        HOST_REQ = 1'b0;
      end
      if (!RESETn) begin
        if (rst_hold == 0) RESETn = 1'b1;
        else rst_hold--;
      end else if ($urandom_range(0, 599) == 0) begin
        RESETn   = 1'b0;
        rst_hold = int'($urandom_range(0, 2));
      end
      drv();
    end
    RESETn = 1'b1;
    wait_n(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
